// File: rtl/tx_channel_arbiter_if.sv
// Beat-level valid/ready stream bundle shared by the aw, ar and tx sides
// of the transmit channel arbiter.
interface tx_channel_arbiter_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH*8-1:0] data;
    logic [DATA_WIDTH-1:0]   keep;
    logic                    last;
    logic [3:0]              connection_id;
    logic [12:0]             byte_num;
    logic                    valid;
    logic                    ready;

    modport master (
        output data, keep, last, connection_id, byte_num, valid,
        input  ready
    );

    modport slave (
        input  data, keep, last, connection_id, byte_num, valid,
        output ready
    );
endinterface

// File: rtl/tx_channel_arbiter.sv
// Packet-granular round-robin merge of the aw and ar streams onto a single
// registered tx stream; a packet holds the grant until its last beat.
module tx_channel_arbiter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    tx_channel_arbiter_if.slave  aw_channel,
    tx_channel_arbiter_if.slave  ar_channel,
    tx_channel_arbiter_if.master tx,
    output logic                 tx_src
);

    typedef enum logic [1:0] {
        IDLE,
        AW_PKT,
        AR_PKT
    } state_e;

    state_e state_q, state_d;

    // 1: ar owned the previous packet, so aw wins the next tie
    logic rr_q, rr_d;

    logic                    valid_q, valid_d;
    logic [DATA_WIDTH*8-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0]   keep_q, keep_d;
    logic                    last_q, last_d;
    logic [3:0]              cid_q, cid_d;
    logic [12:0]             bnum_q, bnum_d;
    logic                    src_q, src_d;

    logic gnt_aw, gnt_ar;
    logic load_en;
    logic acc_aw, acc_ar, acc, acc_last;

    always_comb begin
        gnt_aw = 1'b0;
        gnt_ar = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (aw_channel.valid && (!ar_channel.valid || rr_q))
                    gnt_aw = 1'b1;
                else if (ar_channel.valid)
                    gnt_ar = 1'b1;
            end
            AW_PKT:  gnt_aw = 1'b1;
            AR_PKT:  gnt_ar = 1'b1;
            default: ;
        endcase
    end

    assign load_en = !valid_q || tx.ready;

    assign aw_channel.ready = load_en && gnt_aw && !reset;
    assign ar_channel.ready = load_en && gnt_ar && !reset;

    assign acc_aw   = aw_channel.valid && aw_channel.ready;
    assign acc_ar   = ar_channel.valid && ar_channel.ready;
    assign acc      = acc_aw || acc_ar;
    assign acc_last = acc_ar ? ar_channel.last : aw_channel.last;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        if (acc) begin
            if (acc_last) begin
                state_d = IDLE;
                rr_d    = acc_ar;
            end else begin
                state_d = acc_ar ? AR_PKT : AW_PKT;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        cid_d   = cid_q;
        bnum_d  = bnum_q;
        src_d   = src_q;
        if (load_en) begin
            valid_d = acc;
            if (acc) begin
                data_d = acc_ar ? ar_channel.data : aw_channel.data;
                keep_d = acc_ar ? ar_channel.keep : aw_channel.keep;
                last_d = acc_last;
                cid_d  = acc_ar ? ar_channel.connection_id
                                : aw_channel.connection_id;
                bnum_d = acc_ar ? ar_channel.byte_num
                                : aw_channel.byte_num;
                src_d  = acc_ar;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            cid_q   <= '0;
            bnum_q  <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            cid_q   <= cid_d;
            bnum_q  <= bnum_d;
            src_q   <= src_d;
        end
    end

    assign tx.valid         = valid_q;
    assign tx.data          = data_q;
    assign tx.keep          = keep_q;
    assign tx.last          = last_q;
    assign tx.connection_id = cid_q;
    assign tx.byte_num      = bnum_q;
    assign tx_src           = src_q;

endmodule
